// File: rtl/kl_pkg.sv
// Shared definitions for the issue scoreboard slice.
//   - Default parameter constants for issue_scoreboard.
//   - lane_dec_t: one decoded instruction lane (sources, destination, enables,
//     write flag, result latency, memory flag). Fields are sized for the largest
//     supported configuration; narrower configurations zero-extend into them.
//   - eff_lat(): result latency with a zero latency promoted to one cycle.
package kl_pkg;

    localparam int unsigned DEF_ISSUE_W   = 2;
    localparam int unsigned DEF_NREGS     = 8;
    localparam int unsigned DEF_LAT_W     = 2;
    localparam int unsigned DEF_MEM_PORTS = 1;
    localparam int unsigned DEF_BYPASS    = 1;

    // Upper bounds on register-index and latency widths carried in lane_dec_t.
    localparam int unsigned MAX_RW    = 6;
    localparam int unsigned MAX_LAT_W = 4;

    typedef struct packed {
        logic [MAX_RW-1:0]    rs1;
        logic [MAX_RW-1:0]    rs2;
        logic                 rs1_en;
        logic                 rs2_en;
        logic [MAX_RW-1:0]    rd;
        logic                 we;
        logic [MAX_LAT_W-1:0] lat;
        logic                 mem;
    } lane_dec_t;

    function automatic logic [MAX_LAT_W-1:0] eff_lat(input logic [MAX_LAT_W-1:0] lat);
        return (lat == '0) ? MAX_LAT_W'(1) : lat;
    endfunction

endpackage

// File: rtl/sb_lane_check.sv
// Per-lane readiness against the current scoreboard counters.
// Ports:
//   dec     - decoded lane record
//   cnt     - flattened per-register pending counters, NREGS x LAT_W
//   src_ok  - every enabled source is ready (cnt <= 1 with bypass, else cnt == 0)
//   waw_ok  - a writer's pending counter does not exceed its effective latency
//   lat_eff - effective latency (0 promoted to 1), LAT_W bits, loaded on issue
//   mem_op  - lane is a memory op (forwarded so the top reads one record)
module sb_lane_check
    import kl_pkg::*;
#(
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned LAT_W  = DEF_LAT_W,
    parameter int unsigned BYPASS = DEF_BYPASS
) (
    input  lane_dec_t              dec,
    input  logic [NREGS*LAT_W-1:0] cnt,
    output logic                   src_ok,
    output logic                   waw_ok,
    output logic [LAT_W-1:0]       lat_eff,
    output logic                   mem_op
);

    localparam logic [LAT_W-1:0] READY_MAX = (BYPASS != 0) ? LAT_W'(1) : '0;

    logic [LAT_W-1:0]     cnt_rs1;
    logic [LAT_W-1:0]     cnt_rs2;
    logic [LAT_W-1:0]     cnt_rd;
    logic [MAX_LAT_W-1:0] lat_full;

    // Register-file style read of the three counters this lane cares about.
    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (dec.rs1 == MAX_RW'(r)) cnt_rs1 = cnt[r*LAT_W +: LAT_W];
            if (dec.rs2 == MAX_RW'(r)) cnt_rs2 = cnt[r*LAT_W +: LAT_W];
            if (dec.rd  == MAX_RW'(r)) cnt_rd  = cnt[r*LAT_W +: LAT_W];
        end
    end

    always_comb begin
        lat_full = eff_lat(dec.lat);
        lat_eff  = lat_full[LAT_W-1:0];
        src_ok   = (!dec.rs1_en || (cnt_rs1 <= READY_MAX)) &&
                   (!dec.rs2_en || (cnt_rs2 <= READY_MAX));
        // An older write still outstanding longer than ours would land after us.
        waw_ok   = !dec.we || (MAX_LAT_W'(cnt_rd) <= lat_full);
        mem_op   = dec.mem;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-lane issue scoreboard.
// Tracks a pending-write counter per architectural register and decides,
// combinationally, which prefix of the decoded bundle may issue this cycle.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   in_valid             - per-lane instruction present (lane 0 oldest)
//   in_rs1/in_rs2        - flattened ISSUE_W x RW source indices, with enables
//   in_rd, in_we         - flattened destination index and write flag
//   in_lat               - flattened ISSUE_W x LAT_W result latency
//   in_mem               - per-lane memory op flag
//   flush                - kill all in-flight writes, issue nothing
//   issue_mask/issue_cnt - lanes issuing this cycle and their popcount
//   stall, fetch_next    - some valid lane held back / whole bundle issued
//   busy                 - per-register pending-write flag
//   stall_cycles         - saturating count of stalled cycles
module issue_scoreboard
    import kl_pkg::*;
#(
    parameter int unsigned ISSUE_W   = DEF_ISSUE_W,
    parameter int unsigned NREGS     = DEF_NREGS,
    parameter int unsigned LAT_W     = DEF_LAT_W,
    parameter int unsigned MEM_PORTS = DEF_MEM_PORTS,
    parameter int unsigned BYPASS    = DEF_BYPASS,
    localparam int unsigned RW       = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int unsigned CW       = $clog2(ISSUE_W + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ISSUE_W-1:0]       in_valid,
    input  logic [ISSUE_W*RW-1:0]    in_rs1,
    input  logic [ISSUE_W*RW-1:0]    in_rs2,
    input  logic [ISSUE_W-1:0]       in_rs1_en,
    input  logic [ISSUE_W-1:0]       in_rs2_en,
    input  logic [ISSUE_W*RW-1:0]    in_rd,
    input  logic [ISSUE_W-1:0]       in_we,
    input  logic [ISSUE_W*LAT_W-1:0] in_lat,
    input  logic [ISSUE_W-1:0]       in_mem,
    input  logic                     flush,
    output logic [ISSUE_W-1:0]       issue_mask,
    output logic [CW-1:0]            issue_cnt,
    output logic                     stall,
    output logic                     fetch_next,
    output logic [NREGS-1:0]         busy,
    output logic [15:0]              stall_cycles
);

    logic [NREGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
    logic [15:0]                 stall_cycles_q, stall_cycles_d;

    lane_dec_t [ISSUE_W-1:0]             dec;
    logic [ISSUE_W-1:0]                  src_ok;
    logic [ISSUE_W-1:0]                  waw_ok;
    logic [ISSUE_W-1:0]                  mem_op;
    logic [ISSUE_W-1:0][LAT_W-1:0]       lat_eff;
    logic [NREGS*LAT_W-1:0]              cnt_flat;

    logic        active;
    logic        chain;
    logic        hazard;
    int unsigned mem_used;

    assign cnt_flat = cnt_q;
    assign active   = !reset && !flush;

    // Widen each lane's fields into the shared decode record.
    always_comb begin
        dec = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            dec[i].rs1    = MAX_RW'(in_rs1[i*RW +: RW]);
            dec[i].rs2    = MAX_RW'(in_rs2[i*RW +: RW]);
            dec[i].rs1_en = in_rs1_en[i];
            dec[i].rs2_en = in_rs2_en[i];
            dec[i].rd     = MAX_RW'(in_rd[i*RW +: RW]);
            dec[i].we     = in_we[i];
            dec[i].lat    = MAX_LAT_W'(in_lat[i*LAT_W +: LAT_W]);
            dec[i].mem    = in_mem[i];
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        sb_lane_check #(
            .NREGS  (NREGS),
            .LAT_W  (LAT_W),
            .BYPASS (BYPASS)
        ) u_check (
            .dec     (dec[g]),
            .cnt     (cnt_flat),
            .src_ok  (src_ok[g]),
            .waw_ok  (waw_ok[g]),
            .lat_eff (lat_eff[g]),
            .mem_op  (mem_op[g])
        );
    end

    // In-order issue chain. Once a lane fails, chain stays low so nothing
    // younger issues. When lane i is evaluated with chain high, every earlier
    // lane is valid and issuing, so hazards only need to scan lanes below i.
    always_comb begin
        issue_mask = '0;
        chain      = active;
        hazard     = 1'b0;
        mem_used   = 0;
        for (int i = 0; i < ISSUE_W; i++) begin
            hazard = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (in_we[j]) begin
                    if (in_rs1_en[i] && (in_rs1[i*RW +: RW] == in_rd[j*RW +: RW])) hazard = 1'b1;
                    if (in_rs2_en[i] && (in_rs2[i*RW +: RW] == in_rd[j*RW +: RW])) hazard = 1'b1;
                    if (in_we[i] && (in_rd[i*RW +: RW] == in_rd[j*RW +: RW])) hazard = 1'b1;
                end
            end
            if (mem_op[i] && (mem_used >= MEM_PORTS)) hazard = 1'b1;
            chain         = chain && in_valid[i] && src_ok[i] && waw_ok[i] && !hazard;
            issue_mask[i] = chain;
            if (mem_op[i]) mem_used = mem_used + 1;
        end
    end

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            issue_cnt = issue_cnt + CW'(issue_mask[i]);
        end
        stall      = active && |(in_valid & ~issue_mask);
        fetch_next = active && |in_valid && !stall;
    end

    // Decrement every counter; an issuing writer reloads its destination.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            for (int i = 0; i < ISSUE_W; i++) begin
                if (issue_mask[i] && in_we[i] && (in_rd[i*RW +: RW] == RW'(r))) begin
                    cnt_d[r] = lat_eff[i];
                end
            end
        end
        if (flush) cnt_d = '0;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (default configuration: 2 lanes, 8 regs,
// LAT_W 2, one memory port). A second instance with BYPASS=0 shares the inputs.
module tb_issue_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_valid, in_rs1_en, in_rs2_en, in_we, in_mem;
    logic [5:0] in_rs1, in_rs2, in_rd;
    logic [3:0] in_lat;
    logic       flush;

    logic [1:0]  issue_mask, nb_issue_mask;
    logic [1:0]  issue_cnt, nb_issue_cnt;
    logic        stall, nb_stall, fetch_next, nb_fetch_next;
    logic [7:0]  busy, nb_busy;
    logic [15:0] stall_cycles, nb_stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rs1_en    (in_rs1_en),
        .in_rs2_en    (in_rs2_en),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .in_lat       (in_lat),
        .in_mem       (in_mem),
        .flush        (flush),
        .issue_mask   (issue_mask),
        .issue_cnt    (issue_cnt),
        .stall        (stall),
        .fetch_next   (fetch_next),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    issue_scoreboard #(
        .BYPASS (0)
    ) dut_nb (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rs1_en    (in_rs1_en),
        .in_rs2_en    (in_rs2_en),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .in_lat       (in_lat),
        .in_mem       (in_mem),
        .flush        (flush),
        .issue_mask   (nb_issue_mask),
        .issue_cnt    (nb_issue_cnt),
        .stall        (nb_stall),
        .fetch_next   (nb_fetch_next),
        .busy         (nb_busy),
        .stall_cycles (nb_stall_cycles)
    );

    task automatic clear_lanes();
        in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rs1_en = '0; in_rs2_en = '0;
        in_rd = '0; in_we = '0; in_lat = '0; in_mem = '0; flush = 1'b0;
    endtask

    task automatic set_lane(input int i, input int rs1, input bit e1, input int rs2, input bit e2,
                            input int rd, input bit we, input int lat, input bit mem);
        in_valid[i]       = 1'b1;
        in_rs1[i*3 +: 3]  = 3'(rs1);
        in_rs1_en[i]      = e1;
        in_rs2[i*3 +: 3]  = 3'(rs2);
        in_rs2_en[i]      = e2;
        in_rd[i*3 +: 3]   = 3'(rd);
        in_we[i]          = we;
        in_lat[i*2 +: 2]  = 2'(lat);
        in_mem[i]         = mem;
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_lanes();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_lanes();
        set_lane(0, 0, 0, 0, 0, 1, 1, 1, 0);
        set_lane(1, 3, 1, 0, 0, 2, 1, 1, 0);
        tick();
        n_cmp++; if (issue_mask !== 2'b00) begin n_err++; $display("FAIL rst_mask: got %b want 00", issue_mask); end
        n_cmp++; if (issue_cnt !== 2'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", issue_cnt); end
        n_cmp++; if (stall !== 1'b0 || fetch_next !== 1'b0) begin n_err++; $display("FAIL rst_stall_fetch: got %b%b want 00", stall, fetch_next); end
        n_cmp++; if (busy !== 8'h00) begin n_err++; $display("FAIL rst_busy: got %h want 00", busy); end
        n_cmp++; if (stall_cycles !== 16'h0) begin n_err++; $display("FAIL rst_sc: got %h want 0", stall_cycles); end
    endtask

    // Bundle left presented across reset release issues from a clean board.
    task automatic test_basic();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (issue_mask !== 2'b11) begin n_err++; $display("FAIL basic_mask: got %b want 11", issue_mask); end
        n_cmp++; if (issue_cnt !== 2'd2) begin n_err++; $display("FAIL basic_cnt: got %0d want 2", issue_cnt); end
        n_cmp++; if (fetch_next !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL basic_fetch: got f%b s%b want f1 s0", fetch_next, stall); end
        tick();
        clear_lanes();
        #1;
        n_cmp++; if (busy !== 8'b0000_0110) begin n_err++; $display("FAIL basic_busy: got %b want 00000110", busy); end
        tick();
        n_cmp++; if (busy !== 8'h00) begin n_err++; $display("FAIL basic_busy_clear: got %b want 0", busy); end
    endtask

    task automatic test_raw_bypass();
        do_reset();
        set_lane(0, 0, 0, 0, 0, 3, 1, 2, 1);
        set_lane(1, 3, 1, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (issue_mask !== 2'b01 || stall !== 1'b1) begin n_err++; $display("FAIL raw_bundle: got m%b s%b want m01 s1", issue_mask, stall); end
        n_cmp++; if (nb_issue_mask !== 2'b01) begin n_err++; $display("FAIL raw_bundle_nb: got %b want 01", nb_issue_mask); end
        tick();
        clear_lanes();
        set_lane(0, 3, 1, 0, 0, 0, 0, 0, 0);
        #1;  // cnt[3] = 2
        n_cmp++; if (issue_mask !== 2'b00 || stall !== 1'b1) begin n_err++; $display("FAIL raw_cnt2: got m%b s%b want m00 s1", issue_mask, stall); end
        tick();  // cnt[3] = 1
        n_cmp++; if (issue_mask !== 2'b01 || fetch_next !== 1'b1) begin n_err++; $display("FAIL raw_bypass_cnt1: got m%b f%b want m01 f1", issue_mask, fetch_next); end
        n_cmp++; if (nb_issue_mask !== 2'b00 || nb_stall !== 1'b1) begin n_err++; $display("FAIL raw_nobypass_cnt1: got m%b s%b want m00 s1", nb_issue_mask, nb_stall); end
        tick();  // cnt[3] = 0
        n_cmp++; if (nb_issue_mask !== 2'b01) begin n_err++; $display("FAIL raw_nobypass_cnt0: got %b want 01", nb_issue_mask); end
    endtask

    task automatic test_structural();
        do_reset();
        set_lane(0, 1, 1, 2, 1, 0, 0, 0, 1);
        set_lane(1, 6, 1, 0, 0, 5, 1, 1, 1);
        #1;
        n_cmp++; if (issue_mask !== 2'b01 || stall !== 1'b1) begin n_err++; $display("FAIL mem_port: got m%b s%b want m01 s1", issue_mask, stall); end
        tick();
        n_cmp++; if (stall_cycles !== 16'd1) begin n_err++; $display("FAIL mem_sc: got %0d want 1", stall_cycles); end
        clear_lanes();
        set_lane(0, 6, 1, 0, 0, 5, 1, 1, 1);
        #1;
        n_cmp++; if (issue_mask !== 2'b01 || fetch_next !== 1'b1) begin n_err++; $display("FAIL mem_replay: got m%b f%b want m01 f1", issue_mask, fetch_next); end
        tick();
        n_cmp++; if (stall_cycles !== 16'd1 || busy !== 8'b0010_0000) begin n_err++; $display("FAIL mem_after: got sc%0d b%b want sc1 b00100000", stall_cycles, busy); end
    endtask

    task automatic test_waw();
        do_reset();
        set_lane(0, 0, 0, 0, 0, 4, 1, 1, 0);
        set_lane(1, 0, 0, 0, 0, 4, 1, 1, 0);
        #1;
        n_cmp++; if (issue_mask !== 2'b01) begin n_err++; $display("FAIL waw_bundle: got %b want 01", issue_mask); end
        tick();
        clear_lanes();
        set_lane(0, 0, 0, 0, 0, 5, 1, 3, 0);
        tick();  // cnt[5] = 3
        clear_lanes();
        set_lane(0, 0, 0, 0, 0, 5, 1, 1, 0);
        #1;
        n_cmp++; if (issue_mask !== 2'b00) begin n_err++; $display("FAIL waw_cnt3: got %b want 00", issue_mask); end
        tick();  // cnt[5] = 2, lat 0 counts as 1
        in_lat = '0;
        #1;
        n_cmp++; if (issue_mask !== 2'b00) begin n_err++; $display("FAIL waw_cnt2_lat0: got %b want 00", issue_mask); end
        tick();  // cnt[5] = 1
        n_cmp++; if (issue_mask !== 2'b01) begin n_err++; $display("FAIL waw_cnt1: got %b want 01", issue_mask); end
        tick();
        clear_lanes();
        #1;
        n_cmp++; if (busy !== 8'b0010_0000) begin n_err++; $display("FAIL waw_lat0_load: got %b want 00100000", busy); end
    endtask

    task automatic test_flush();
        do_reset();
        set_lane(0, 0, 0, 0, 0, 0, 1, 3, 1);
        tick();
        clear_lanes();
        set_lane(0, 0, 1, 0, 0, 1, 0, 0, 0);
        flush = 1'b1;
        #1;
        n_cmp++; if (issue_mask !== 2'b00 || stall !== 1'b0 || fetch_next !== 1'b0) begin n_err++; $display("FAIL flush_out: got m%b s%b f%b want 00 0 0", issue_mask, stall, fetch_next); end
        n_cmp++; if (busy !== 8'b0000_0001) begin n_err++; $display("FAIL flush_busy_before: got %b want 00000001", busy); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (busy !== 8'h00) begin n_err++; $display("FAIL flush_busy_after: got %b want 0", busy); end
        n_cmp++; if (issue_mask !== 2'b01 || fetch_next !== 1'b1) begin n_err++; $display("FAIL flush_reader: got m%b f%b want m01 f1", issue_mask, fetch_next); end
        n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL flush_sc: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_gap_saturate();
        do_reset();
        set_lane(1, 0, 0, 0, 0, 6, 1, 1, 0);
        #1;
        n_cmp++; if (issue_mask !== 2'b00 || stall !== 1'b1 || fetch_next !== 1'b0) begin n_err++; $display("FAIL gap: got m%b s%b f%b want 00 1 0", issue_mask, stall, fetch_next); end
        tick();
        n_cmp++; if (busy !== 8'h00 || stall_cycles !== 16'd1) begin n_err++; $display("FAIL gap_after: got b%b sc%0d want 0 1", busy, stall_cycles); end
        repeat (70000) tick();
        n_cmp++; if (stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sc_saturate: got %h want ffff", stall_cycles); end
        clear_lanes();
        set_lane(0, 0, 0, 0, 0, 7, 1, 3, 0);
        tick();
        n_cmp++; if (busy !== 8'b1000_0000 || stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL pre_reset: got b%b sc%h want 10000000 ffff", busy, stall_cycles); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (stall_cycles !== 16'h0 || busy !== 8'h00) begin n_err++; $display("FAIL async_reset: got sc%h b%b want 0 0", stall_cycles, busy); end
        n_cmp++; if (issue_mask !== 2'b00 || fetch_next !== 1'b0) begin n_err++; $display("FAIL reset_gate: got m%b f%b want 00 0", issue_mask, fetch_next); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (issue_mask !== 2'b01) begin n_err++; $display("FAIL post_reset_issue: got %b want 01", issue_mask); end
    endtask

    initial begin
        reset = 1'b1;
        clear_lanes();
        test_reset();
        test_basic();
        test_raw_bypass();
        test_structural();
        test_waw();
        test_flush();
        test_gap_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter ISSUE_W, default 2, number of in-order issue lanes (1..4).
REQ-002 SHALL have parameter NREGS, default 8, architectural registers; RW = $clog2(NREGS).
REQ-003 SHALL have parameter LAT_W, default 2, width of per-instruction result latency.
REQ-004 SHALL have parameter MEM_PORTS, default 1, max memory ops issued per cycle.
REQ-005 SHALL have parameter BYPASS, default 1, 1 = source ready when pending count is at most 1, 0 = only when 0.
REQ-006 Ports, clock and reset first: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-007 in_valid in ISSUE_W, lane holds a decoded instruction; lane 0 is oldest.
REQ-008 in_rs1, in_rs2 in ISSUE_W x RW sources; in_rs1_en, in_rs2_en in ISSUE_W source used.
REQ-009 in_rd in ISSUE_W x RW destination; in_we in ISSUE_W writes rd; in_lat in ISSUE_W x LAT_W cycles until result; in_mem in ISSUE_W memory op.
REQ-010 flush in 1 kill all in-flight writes; issue_mask out ISSUE_W lanes issuing this cycle; issue_cnt out $clog2(ISSUE_W+1) popcount.
REQ-011 stall out 1, a valid lane not issued; fetch_next out 1, every valid lane issued; busy out NREGS, cnt nonzero; stall_cycles out 16 saturating stall counter.

Function
REQ-012 SHALL keep per-register counter cnt[r], LAT_W bits, 0 = no pending write.
REQ-013 Source ready: enable low, or cnt at most 1 (BYPASS=1) / cnt 0 (BYPASS=0).
REQ-014 Lane i SHALL issue only if in_valid[i], all lanes below i issue, and every rule REQ-015..REQ-018 holds; issue is strictly in order, no lane issues past a blocked one.
REQ-015 Intra-bundle RAW: lane i blocked if an enabled source equals in_rd of an earlier issuing lane with in_we.
REQ-016 Intra-bundle WAW: lane i blocked if in_we[i] and in_rd[i] equals in_rd of an earlier issuing writer.
REQ-017 Pending WAW: writer blocked if cnt[in_rd] exceeds effective latency.
REQ-018 Structural: lane blocked if it would make in_mem issues this cycle exceed MEM_PORTS.
REQ-019 Effective latency = in_lat, in_lat 0 treated as 1.
REQ-020 issue_mask, issue_cnt, stall, fetch_next SHALL be combinational from inputs and current cnt; zero-latency.
REQ-021 Each posedge: every cnt decrements saturating at 0; an issuing writer loads cnt[in_rd] = effective latency, load overriding decrement.
REQ-022 stall = any in_valid lane with issue_mask 0; fetch_next = in_valid nonzero and no stall; both 0 when in_valid all 0.
REQ-023 flush high: issue_mask forced 0, stall and fetch_next 0, all cnt cleared at next edge; stall_cycles not incremented.
REQ-024 stall_cycles increments on each edge with stall high, saturates at 16'hFFFF.
REQ-025 Non-contiguous in_valid (gap): lanes above first invalid lane SHALL NOT issue.

Reset
REQ-026 reset high SHALL asynchronously clear all cnt and stall_cycles; busy reads 0 immediately.
REQ-027 During reset issue_mask, issue_cnt, stall, fetch_next SHALL be 0 regardless of inputs.
REQ-028 Reset deasserted mid-bundle: bundle re-evaluated from clean scoreboard on first edge after release.

Structure
REQ-029 Shared package (kl_pkg) SHALL hold the lane-decode struct type (rs1, rs2, rd, enables, we, lat, mem) and default parameter constants.
REQ-030 One sub-module, sb_lane_check, SHALL evaluate per-lane readiness (REQ-013, REQ-017); in-order chaining, RAW/WAW/structural logic in top.

Verification
REQ-031 Reset then lane0 ADD R1 lat1, lane1 ADD R2 from R3 -> issue_mask 2'b11, fetch_next 1, busy[1] and busy[2] set for one cycle.
REQ-032 Lane0 LDR R3 lat2, lane1 reads R3 -> issue_mask 2'b01, stall 1; next cycle R3-reader alone, BYPASS=1: issues (cnt=1); BYPASS=0: stalls once more.
REQ-033 Lane0 STR, lane1 LDR, MEM_PORTS=1 -> issue_mask 2'b01, stall_cycles +1; re-presented LDR issues next cycle.
REQ-034 Lane0 writes R4 lat1, lane1 writes R4 -> lane1 blocked (WAW); pending cnt[R5]=3 and new lat1 writer of R5 -> blocked until cnt at most 1.
REQ-035 After LDR R0 lat3 issued, assert flush -> issue_mask 0; next cycle busy 0, R0-reader issues immediately.
REQ-036 Hold an unissuable bundle 70000 cycles -> stall_cycles saturates at 16'hFFFF; async reset mid-cycle -> counter and busy 0 before next edge.
